// File: rtl/scan_chain_pkg.sv
// Shared types and helpers for the scan chain node: FSM state encoding and counter width.
package scan_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_UPDATE  = 2'd3
  } state_e;

  function automatic int cnt_w(input int data_len);
    return (data_len > 2) ? $clog2(data_len) : 1;
  endfunction

endpackage

// File: rtl/scan_chain_lane.sv
// One serial lane: shift register with parallel load and a parallel output shadow register.
module scan_lane #(
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                load_en,
  input  logic                update_en,
  input  logic                data_in,
  input  logic [DATA_LEN-1:0] capture_in,
  output logic                data_out,
  output logic [DATA_LEN-1:0] bit_out
);

  logic [DATA_LEN-1:0] sr_q, sr_d;
  logic [DATA_LEN-1:0] bit_out_q, bit_out_d;

  // Next-state for the shift and shadow registers; load wins over shift.
  always_comb begin
    sr_d      = sr_q;
    bit_out_d = bit_out_q;
    if (load_en) begin
      sr_d = capture_in;
    end else if (shift_en) begin
      sr_d = {data_in, sr_q[DATA_LEN-1:1]};
    end else begin
      sr_d = sr_q;
    end
    if (update_en) begin
      bit_out_d = sr_q;
    end else begin
      bit_out_d = bit_out_q;
    end
  end

  // Lane state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      bit_out_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_out_q <= bit_out_d;
    end
  end

  assign data_out = sr_q[0];
  assign bit_out  = bit_out_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Self-sequencing daisy-chain node: frame FSM, bit counter and LANES serial lanes.
// Define SCAN_CAPTURE_EN to add the parallel CAPTURE state at the start of every frame.
module scan_chain_ctrl
  import scan_chain_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int LANES    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      enable,
  input  logic [LANES-1:0]          data_in,
  input  logic [LANES*DATA_LEN-1:0] capture_in,
  output logic [LANES-1:0]          data_out,
  output logic [LANES*DATA_LEN-1:0] bit_out,
  output logic                      busy,
  output logic                      done
);

  localparam int             CW       = cnt_w(DATA_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shift_en, load_en, update_en;

  // Frame sequencing: next state, counter and lane strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    update_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef SCAN_CAPTURE_EN
          state_d = ST_CAPTURE;
`else
          state_d = ST_SHIFT;
          cnt_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        load_en = 1'b1;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (enable) begin
          shift_en = 1'b1;
          // Counter saturates on the last shift so it never wraps inside a frame.
          if (cnt_q == CNT_LAST) begin
            state_d = ST_UPDATE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_UPDATE: begin
        update_en = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and bit counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_UPDATE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    scan_lane #(.DATA_LEN(DATA_LEN)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .shift_en   (shift_en),
      .load_en    (load_en),
      .update_en  (update_en),
      .data_in    (data_in[l]),
      .capture_in (capture_in[l*DATA_LEN +: DATA_LEN]),
      .data_out   (data_out[l]),
      .bit_out    (bit_out[l*DATA_LEN +: DATA_LEN])
    );
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl (DATA_LEN=8, LANES=2) with a frame-level reference model.
module tb_scan_chain_ctrl;

  localparam int DL = 8;
  localparam int NL = 2;
`ifdef SCAN_CAPTURE_EN
  localparam int CAPD = 1;
`else
  localparam int CAPD = 0;
`endif
  localparam int SH0 = 1 + CAPD;

  logic             clk = 1'b0;
  logic             reset, start, enable;
  logic [NL-1:0]    data_in;
  logic [NL*DL-1:0] capture_in;
  logic [NL-1:0]    data_out;
  logic [NL*DL-1:0] bit_out;
  logic             busy, done;

  int n_checks = 0;
  int n_errors = 0;

  scan_chain_ctrl #(.DATA_LEN(DL), .LANES(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .enable     (enable),
    .data_in    (data_in),
    .capture_in (capture_in),
    .data_out   (data_out),
    .bit_out    (bit_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is "pending capture", then a run of DL enabled shifts, then one update.
  logic       m_valid = 1'b0;
  logic       m_cap, m_shifting, m_upd;
  int         m_nshift;
  logic [DL-1:0] m_sr [NL];
  logic [NL*DL-1:0] m_bo;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {63'd0, busy}, {63'd0, (m_cap | m_shifting | m_upd)});
      chk("done", {63'd0, done}, {63'd0, m_upd});
      chk("data_out", 64'(data_out), 64'({m_sr[1][0], m_sr[0][0]}));
      chk("bit_out", 64'(bit_out), 64'(m_bo));
    end
    if (reset) begin
      m_valid = 1'b1;
      m_cap = 1'b0; m_shifting = 1'b0; m_upd = 1'b0; m_nshift = 0;
      for (int l = 0; l < NL; l++) m_sr[l] = '0;
      m_bo = '0;
    end else if (m_valid) begin
      if (m_upd) begin
        for (int l = 0; l < NL; l++) m_bo[l*DL +: DL] = m_sr[l];
        m_upd = 1'b0;
      end else if (m_cap) begin
        for (int l = 0; l < NL; l++) m_sr[l] = capture_in[l*DL +: DL];
        m_cap = 1'b0; m_shifting = 1'b1; m_nshift = 0;
      end else if (m_shifting) begin
        if (enable) begin
          for (int l = 0; l < NL; l++) m_sr[l] = {data_in[l], m_sr[l][DL-1:1]};
          m_nshift++;
          if (m_nshift == DL) begin
            m_shifting = 1'b0; m_upd = 1'b1;
          end
        end
      end else if (start) begin
        if (CAPD == 1) m_cap = 1'b1;
        else begin m_shifting = 1'b1; m_nshift = 0; end
      end
    end
  end

  // Runs cycles 0..15 of one frame; cycle 0 is the one in which start is sampled.
  task automatic run_frame(input logic [NL*DL-1:0] cap, input logic [DL-1:0] w0, input logic [DL-1:0] w1,
                           input int st_lo, input int st_hi, input int extra_start, input int rst_cyc,
                           output int done_c, output int busy_lo, output int busy_hi,
                           output logic [DL-1:0] e0, output logic [DL-1:0] e1);
    int k;
    logic use_bit;
    done_c = -1; busy_lo = -1; busy_hi = -1; e0 = '0; e1 = '0; k = 0;
    capture_in = cap;
    for (int n = 0; n < 16; n++) begin
      start   = (n == 0) || (n == extra_start);
      reset   = (n == rst_cyc);
      enable  = !(n >= st_lo && n <= st_hi);
      use_bit = (n >= SH0) && enable && (k < DL);
      data_in = use_bit ? {w1[k], w0[k]} : 2'b00;
      @(negedge clk);
      if (n >= SH0 && n < SH0 + DL) begin
        e0[n-SH0] = data_out[0];
        e1[n-SH0] = data_out[1];
      end
      if (done && done_c < 0) done_c = n;
      if (busy) begin
        if (busy_lo < 0) busy_lo = n;
        busy_hi = n;
      end
      if (use_bit) k++;
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b0; enable = 1'b0; data_in = 2'b00;
  endtask

  int dc, bl, bh;
  logic [DL-1:0] e0, e1;

  initial begin
    // Scenario 1: reset for two cycles with random inputs.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); enable = 1'($urandom);
      data_in = 2'($urandom_range(0, 3)); capture_in = 16'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b0; start = 1'b0; enable = 1'b0; data_in = 2'b00; capture_in = 16'h0000;
    @(negedge clk);
    chk("rst_bit_out", 64'(bit_out), 64'h0);
    chk("rst_data_out", 64'(data_out), 64'h0);
    chk("rst_busy", {63'd0, busy}, 64'h0);
    chk("rst_done", {63'd0, done}, 64'h0);
    @(posedge clk); #1;

    // Scenario 2: basic frame, lane0 0xA5, lane1 0x3C.
    run_frame(16'h0000, 8'hA5, 8'h3C, 99, 99, -1, -1, dc, bl, bh, e0, e1);
    chk("basic_done_cyc", 64'(dc), 64'(9 + CAPD));
    chk("basic_busy_first", 64'(bl), 64'd1);
    chk("basic_busy_last", 64'(bh), 64'(9 + CAPD));
    chk("basic_bit_out", 64'(bit_out), 64'h3CA5);

    // Scenario 3 / 6: capture_in drives the outgoing word only when capture exists.
    run_frame(16'h0081, 8'h11, 8'h22, 99, 99, -1, -1, dc, bl, bh, e0, e1);
`ifdef SCAN_CAPTURE_EN
    chk("cap_lane0_out", 64'(e0), 64'h81);
    chk("cap_lane1_out", 64'(e1), 64'h00);
`else
    chk("echo_lane0_out", 64'(e0), 64'hA5);
    chk("echo_lane1_out", 64'(e1), 64'h3C);
`endif
    chk("cap_bit_out", 64'(bit_out), 64'h2211);

    // Scenario 4: enable low in cycles 4..6 delays done by three cycles.
    run_frame(16'h0000, 8'hA5, 8'h3C, 4, 6, -1, -1, dc, bl, bh, e0, e1);
    chk("stall_done_cyc", 64'(dc), 64'(12 + CAPD));
    chk("stall_bit_out", 64'(bit_out), 64'h3CA5);

    // Scenario 5: start mid-frame ignored, reset in cycle 6 aborts.
    run_frame(16'h0000, 8'h5A, 8'hC3, 99, 99, 5, 6, dc, bl, bh, e0, e1);
    chk("abort_no_done", 64'(dc), 64'(-1));
    chk("abort_busy_last", 64'(bh), 64'd6);
    chk("abort_bit_out", 64'(bit_out), 64'h0);
    chk("abort_busy", {63'd0, busy}, 64'h0);
    run_frame(16'h0000, 8'hA5, 8'h3C, 99, 99, -1, -1, dc, bl, bh, e0, e1);
    chk("after_abort_done_cyc", 64'(dc), 64'(9 + CAPD));
    chk("after_abort_bit_out", 64'(bit_out), 64'h3CA5);

    // Scenario 6 style: all-ones capture_in.
    run_frame(16'hFFFF, 8'h0F, 8'hF0, 99, 99, -1, -1, dc, bl, bh, e0, e1);
`ifdef SCAN_CAPTURE_EN
    chk("ones_lane0_out", 64'(e0), 64'hFF);
    chk("ones_lane1_out", 64'(e1), 64'hFF);
`else
    chk("ones_lane0_out", 64'(e0), 64'hA5);
    chk("ones_lane1_out", 64'(e1), 64'h3C);
`endif
    chk("ones_done_cyc", 64'(dc), 64'(9 + CAPD));
    chk("ones_bit_out", 64'(bit_out), 64'hF00F);

    // Back-to-back frames with start held high and random serial data.
    start = 1'b1; enable = 1'b1; capture_in = 16'h1234;
    for (int i = 0; i < 36; i++) begin
      data_in = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Parametrised, self-sequencing daisy-chain register: `LANES` independent serial lanes, each `DATA_LEN` bits deep. A start pulse runs one complete frame:
- optional parallel capture;
- exactly `DATA_LEN` enable-gated shift cycles;
- a single update that copies each lane's shift register into its parallel output register.

The block is the next-generation chain node. It replaces externally timed update pulses with an internal bit counter and a `busy`/`done` handshake toward the chain master.

## Interface
- `DATA_LEN`, default 8: bits per lane; legal values ≥ 2.
- `LANES`, default 1: number of parallel serial lanes; legal values ≥ 1.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `enable`  in  1  shift qualifier; in SHIFT, low stalls the frame.
- `data_in`  in  `LANES`  serial input, bit l feeds lane l.
- `capture_in`  in  `LANES*DATA_LEN`  parallel load data; lane l at `[l*DATA_LEN +: DATA_LEN]`.
- `data_out`  out  `LANES`  serial output, bit l = bit 0 of lane l's shift register.
- `bit_out`  out  `LANES*DATA_LEN`  parallel output register; same lane packing as `capture_in`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse in the UPDATE state.

## Operation
- **Reset.** Clears state to IDLE, the counter to 0, all shift registers to 0 and `bit_out` to 0. Consequently `data_out` = 0, `busy` = 0 and `done` = 0.
- **Shift direction.** Per lane, `sr <= {data_in[l], sr[DATA_LEN-1:1]}`, and `data_out[l] = sr[0]`. The first bit shifted in lands in bit 0 after `DATA_LEN` shifts; words therefore travel LSB first.
- **IDLE**
  - `start` = 1 → CAPTURE (macro on) or SHIFT (macro off).
  - `start` = 0 → stay in IDLE.
  - Shift registers hold their contents.
- **CAPTURE**
  - Lasts one cycle regardless of `enable`.
  - All lanes load `sr <= capture_in` lane slice; counter ← 0.
  - Next state: SHIFT.
- **SHIFT**
  - `enable` = 1: all lanes shift together and the counter increments. A shift performed while the counter = `DATA_LEN-1` moves the state to UPDATE.
  - `enable` = 0: registers and counter hold, state unchanged.
- **UPDATE**
  - `bit_out <= sr` for all lanes; `done` = 1.
  - No shift occurs.
  - Next state: IDLE.
- **Counter.** Width `$clog2(DATA_LEN)`; it never wraps within a frame and is cleared on entry to SHIFT.
- **`start` outside IDLE** is ignored; it is not queued.
- **Back-to-back frames.** `start` held high continuously gives back-to-back frames with one IDLE cycle between them.
- **`bit_out`** changes only in UPDATE or on reset.
- **Reset mid-frame** aborts the frame. No update occurs and `bit_out` is cleared.

## Timing
- Counting from the cycle in which `start` is sampled (cycle 0), with `enable` held high:
  - Macro on: CAPTURE in cycle 1, SHIFT in cycles 2..`DATA_LEN`+1, UPDATE/`done` in cycle `DATA_LEN`+2; new `bit_out` is visible from cycle `DATA_LEN`+3.
  - Macro off: every stage is one cycle earlier.
- `busy` rises in cycle 1 and falls in the cycle after UPDATE.
- Each low cycle of `enable` during SHIFT delays `done` by exactly one cycle.
- `data_out` is combinational from `sr[0]`. It is valid throughout SHIFT, and the downstream node samples it on the same edge that shifts this node.

## Configuration
- **`SCAN_CAPTURE_EN` defined:** CAPTURE state exists and `capture_in` is loaded at the start of every frame.
- **`SCAN_CAPTURE_EN` undefined:**
  - No CAPTURE state; IDLE goes directly to SHIFT, and the counter is cleared on that transition.
  - `capture_in` is unused. The port remains for a stable interface.
  - Shift registers enter the frame holding the previous frame's contents, so the previous received word is echoed on `data_out`.

## Structure
- Package `scan_chain_pkg` holds:
  - the state enum typedef (IDLE, CAPTURE, SHIFT, UPDATE);
  - a `cnt_w(DATA_LEN)` width function.
- Sub-module `scan_lane` implements one lane: its shift register, parallel load, and `bit_out` shadow register.
  - It is driven by shared `shift_en`, `load_en` and `update_en` strobes.
  - It is instantiated `LANES` times by a generate loop.
- The FSM and counter live once in `scan_chain_ctrl`.

## Test plan
Parameters for all scenarios: `DATA_LEN` = 8, `LANES` = 2, macro on unless stated.
1. **Reset.** Assert `reset` 2 cycles with random inputs → `bit_out` = 0, `data_out` = 0, `busy` = 0, `done` = 0 on the first cycle after release.
2. **Basic frame.** `start` at cycle 0; lane0 shifts in 0xA5 and lane1 0x3C, LSB first, in cycles 2..9 → `done` in cycle 10 only; `bit_out` = 0x3CA5 from cycle 11; `busy` high in cycles 1..10.
3. **Capture.** `capture_in` = 0x0081 → lane0 `data_out` over SHIFT = 1,0,0,0,0,0,0,1; lane1 `data_out` = 0 throughout.
4. **Stall.** `enable` low in cycles 4..6 → `done` moves to cycle 13; `bit_out` equals the same frame as scenario 2.
5. **Ignored start and abort.** `start` pulsed in cycle 5 mid-frame → no effect. Then `reset` in SHIFT cycle 6 → IDLE, `bit_out` = 0, `busy` = 0; the next frame completes normally in 11 cycles.
6. **Macro undefined.** Repeat scenario 2 → `done` in cycle 9; `capture_in` = 0xFFFF has no effect on `data_out`.
